// File: rtl/framebuffer_reader.sv
// Streams a rendered framebuffer from RAM through a small prefetch FIFO to the SNES byte read port.
// Optional feature macro: FB_READER_UNDERRUN_COUNT_EN adds the saturating underrunCount output.
module framebuffer_reader #(
  parameter logic [15:0] FB_BASE_ADDR = 16'h0000,
  parameter int unsigned PIXEL_COUNT  = 32000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_tick,
  output logic        done_tick,
  output logic        busy,
  input  logic        readerOK,
  output logic        readerRead,
  output logic [15:0] readerReadAddr,
  input  logic        readerReadValid,
  input  logic [15:0] readerReadData,
  input  logic        snesReadStrobe,
  output logic [7:0]  snesReadData,
  output logic        snesDataReady
`ifdef FB_READER_UNDERRUN_COUNT_EN
  ,
  output logic [15:0] underrunCount
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PIX_W = $clog2(PIXEL_COUNT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_COUNT - 1);

  typedef enum logic [1:0] {
    FR_Idle,
    FR_Stream,
    FR_Drain,
    FR_Done
  } state_t;

  state_t state, state_next;

  logic [15:0]      req_addr;
  logic [PIX_W-1:0] req_count;
  logic [PIX_W-1:0] pop_count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             byte_sel;
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [15:0]      head;

  logic start_accept;
  logic credit_ok;
  logic push;
  logic consume;
  logic pop;

  assign start_accept   = start_tick && (state == FR_Idle);
  // Credits count words requested but not yet popped; a same-cycle pop frees nothing until next cycle.
  assign credit_ok      = (outstanding + fifo_count) < DEPTH_C;
  assign push           = readerReadValid && (state != FR_Idle);
  assign snesDataReady  = (fifo_count != '0);
  assign consume        = snesReadStrobe && snesDataReady;
  assign pop            = consume && byte_sel;
  assign head           = fifo_mem[rd_ptr];
  assign snesReadData   = !snesDataReady ? 8'h00 : (byte_sel ? head[15:8] : head[7:0]);
  assign readerReadAddr = req_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FR_Idle;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    readerRead = 1'b0;
    busy       = 1'b0;
    done_tick  = 1'b0;
    unique case (state)
      FR_Idle: begin
        if (start_tick) state_next = FR_Stream;
      end
      FR_Stream: begin
        busy       = 1'b1;
        readerRead = readerOK && credit_ok;
        if (readerRead && (req_count == LAST_PIX)) state_next = FR_Drain;
      end
      FR_Drain: begin
        busy = 1'b1;
        if (pop && (pop_count == LAST_PIX)) state_next = FR_Done;
      end
      FR_Done: begin
        done_tick  = 1'b1;
        state_next = FR_Idle;
      end
      default: state_next = FR_Idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || start_accept) begin
      req_addr    <= FB_BASE_ADDR;
      req_count   <= '0;
      pop_count   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      byte_sel    <= 1'b0;
    end else begin
      if (readerRead) begin
        req_addr  <= req_addr + 16'd1;
        req_count <= req_count + PIX_W'(1);
      end
      outstanding <= outstanding + CNT_W'(readerRead) - CNT_W'(push);
      fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (consume) byte_sel <= ~byte_sel;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        pop_count <= pop_count + PIX_W'(1);
      end
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; fifo_count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= readerReadData;
  end

`ifdef FB_READER_UNDERRUN_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset || start_accept) begin
      underrunCount <= '0;
    end else if (snesReadStrobe && busy && !snesDataReady && (underrunCount != 16'hFFFF)) begin
      underrunCount <= underrunCount + 16'd1;
    end
  end
`endif

endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Read-side counterpart to the renderer's framebuffer write path. After a frame completes, it streams the rendered framebuffer out of framebuffer RAM word by word. Words are prefetched into a small FIFO and served as a byte stream to the SNES-side DMA read port. It arbitrates with the write scheduler through the same RAM grant style: an OK input and a one-cycle request pulse.

## Interface
Parameters:
- FB_BASE_ADDR, 16'h0000, first framebuffer word address
- PIXEL_COUNT, 32000, words per frame (200x160)
- FIFO_DEPTH, 4, prefetch FIFO depth in 16-bit words (power of two, 2..16)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_tick  in  1  one-cycle pulse; begins a frame readout
- done_tick  out  1  one-cycle pulse when the last byte has been consumed
- busy  out  1  high from the cycle after an accepted start_tick until done_tick
- readerOK  in  1  RAM arbiter grant; a request may issue only while high
- readerRead  out  1  one-cycle read request
- readerReadAddr  out  16  word address, valid with readerRead
- readerReadValid  in  1  returned-data strobe; responses arrive in request order, latency ≥1 cycle
- readerReadData  in  16  returned word, valid with readerReadValid
- snesReadStrobe  in  1  one-cycle pulse per consumed byte
- snesReadData  out  8  current byte
- snesDataReady  out  1  high when snesReadData is valid (FIFO non-empty)

## Operation
States:
- FR_Idle: start_tick → FR_Stream. On entry to FR_Stream, reqAddr=FB_BASE_ADDR, reqCount=0, popCount=0, byteSel=0, FIFO empty.
- FR_Stream: issues requests; reqCount==PIXEL_COUNT → FR_Drain.
- FR_Drain: no further requests. The word pop that brings popCount to PIXEL_COUNT → FR_Done.
- FR_Done: done_tick=1 for one cycle, then FR_Idle.

Request rule:
- readerRead=1 iff state==FR_Stream, readerOK=1, and outstanding+fifoCount < FIFO_DEPTH. Both terms are registered values.
- A pop in the same cycle does not free a credit until the next cycle.
- On issue: reqAddr+=1 (16-bit wrap), reqCount+=1, outstanding+=1.
- readerReadValid: push readerReadData into the FIFO and decrement outstanding. It is ignored in FR_Idle.
- Overflow is impossible by the credit rule.

Byte output:
- snesReadData = byteSel ? head[15:8] : head[7:0] (low byte first); 8'h00 when the FIFO is empty.
- snesReadStrobe with snesDataReady=1: byteSel toggles. If byteSel was 1, the head is popped and popCount+=1.
- snesReadStrobe with snesDataReady=0 is an underrun: no state change.
- A push and a pop in the same cycle are both performed; fifoCount is unchanged.

Other conditions:
- start_tick while busy is ignored.
- Reset mid-frame returns the block to FR_Idle with all counters, pointers and the FIFO cleared. Late readerReadValid pulses are then dropped.
- Reset values: done_tick=0, busy=0, readerRead=0, readerReadAddr=FB_BASE_ADDR, snesReadData=8'h00, snesDataReady=0.

## Timing
- start_tick at cycle N → busy=1 at N+1. The first readerRead can be no earlier than N+1, if readerOK is high.
- A word returned at cycle M has snesDataReady=1 at M+1 (FIFO registered).
- A byte strobe at cycle K → next byte visible at K+1.
- Sustained throughput: 1 request per cycle while granted. With FIFO_DEPTH ≥ latency+1 the SNES side never underruns at ≤1 byte/cycle.
- done_tick asserts the cycle after the final high-byte strobe. busy drops in the same cycle.

## Configuration
- FB_READER_UNDERRUN_COUNT_EN defined: adds output underrunCount (16 bits, saturating at 16'hFFFF).
  - Increments on every snesReadStrobe while busy and snesDataReady=0.
  - Clears on accepted start_tick and on reset.
- Undefined: the port is absent and underruns are silently ignored.

## Test plan
- PIXEL_COUNT=4, FB_BASE_ADDR=16'h0100, RAM latency 2, readerOK=1, words 16'hA1B2,16'hC3D4,16'hE5F6,16'h0718 → requests to 0x0100..0x0103 on consecutive cycles; bytes B2,A1,D4,C3,F6,E5,18,07; done_tick once after the 8th strobe.
- FIFO_DEPTH=4, no strobes, latency 1 → exactly 4 requests issued, then readerRead stays 0 until the first word pops.
- readerOK toggled 1,0,1,0 → requests only in granted cycles; addresses contiguous with no skips or duplicates.
- snesReadStrobe before the first data → snesReadData=8'h00, nothing consumed; with FB_READER_UNDERRUN_COUNT_EN, underrunCount=1.
- Reset asserted after 2 of 4 words are read, with a response still in flight → busy=0, FIFO empty. The late readerReadValid is ignored. A new start_tick restarts from FB_BASE_ADDR.
- start_tick pulsed while busy → no restart, reqCount is unaffected, and done_tick fires exactly once.
